mem_responder: RTL and testbench

Memory-side responder for the 9-bit multicycle processor bus. It owns the processor's ADDR and DOUT registers and serves fetches and loads from a 128-word synchronous RAM. Stores are committed to the RAM or to a memory-mapped LED register, and reads of a synchronized switch port are returned on `din`. A serial program-loader port fills the RAM while the processor is held stalled.

---
 rtl/mem_pkg.sv | 30 +++
 rtl/mem_responder_if.sv | 11 +
 rtl/d_ff.sv | 14 +
 rtl/mem_responder_sync_ram.sv | 28 ++
 rtl/mem_responder.sv | 128 ++++++++++++
 tb/tb_mem_responder.sv | 222 ++++++++++++++++++++++
 6 files changed

// File: rtl/mem_pkg.sv
// Shared types for the memory responder: address-map regions and loader states.
package mem_pkg;

  localparam logic [1:0] REG_RAM = 2'b00;
  localparam logic [1:0] REG_LED = 2'b01;
  localparam logic [1:0] REG_SW  = 2'b10;

  typedef enum logic [1:0] {
    RGN_RAM  = 2'b00,
    RGN_LED  = 2'b01,
    RGN_SW   = 2'b10,
    RGN_NONE = 2'b11
  } mem_region_t;

  typedef enum logic [1:0] {
    LD_IDLE    = 2'b00,
    LD_LOAD    = 2'b01,
    LD_RELEASE = 2'b10
  } ld_state_t;

  function automatic mem_region_t decode_region(input logic [1:0] sel);
    case (sel)
      REG_RAM: return RGN_RAM;
      REG_LED: return RGN_LED;
      REG_SW:  return RGN_SW;
      default: return RGN_NONE;
    endcase
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Processor-side bus between the multicycle CPU and the memory responder.
interface mem_responder_if #(parameter int DATA_W = 9);
  logic [DATA_W-1:0] bus;
  logic              addr_in;
  logic              dout_in;
  logic              w_d;
  logic [DATA_W-1:0] din;

  modport master (output bus, addr_in, dout_in, w_d, input din);
  modport slave  (input bus, addr_in, dout_in, w_d, output din);
endinterface

// File: rtl/d_ff.sv
// Enabled register with asynchronous active-low clear.
module d_ff #(parameter int W = 9) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  // hold unless enabled
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) q <= {W{1'b0}};
    else if (en) q <= d;
  end
endmodule

// File: rtl/mem_responder_sync_ram.sv
// Synchronous RAM, read-before-write, whose output register also carries non-RAM read data.
module sync_ram #(
  parameter int DATA_W = 9,
  parameter int RAM_AW = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [RAM_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [RAM_AW-1:0] raddr,
  input  logic              rd_mem,
  input  logic [DATA_W-1:0] alt,
  output logic [DATA_W-1:0] q
);
  logic [DATA_W-1:0] mem_r [0:(1<<RAM_AW)-1];

  // storage array, deliberately not reset
  always_ff @(posedge clk) begin
    if (we) mem_r[waddr] <= wdata;
  end

  // read register sees the pre-write word on a colliding edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) q <= {DATA_W{1'b0}};
    else      q <= rd_mem ? mem_r[raddr] : alt;
  end
endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: ADDR/DOUT registers, address decode, LED/switch ports, program loader.
module mem_responder
  import mem_pkg::*;
#(
  parameter int DATA_W = 9,
  parameter int RAM_AW = 7
) (
  input  logic              clk,
  input  logic              rst,
  mem_responder_if.slave    cpu,
  input  logic [DATA_W-1:0] sw,
  output logic [DATA_W-1:0] led,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              cpu_hold,
  output logic              ld_ovf
);
  logic [DATA_W-1:0] addr_q;
  logic [DATA_W-1:0] dout_q;
  logic [DATA_W-1:0] sw_meta_r;
  logic [DATA_W-1:0] sw_sync_r;
  logic [RAM_AW-1:0] ld_ptr_r;
  ld_state_t         ld_state_r;
  mem_region_t       region_s;
  logic              ram_we_s;
  logic [RAM_AW-1:0] ram_waddr_s;
  logic [DATA_W-1:0] ram_wdata_s;
  logic              led_we_s;
  logic [DATA_W-1:0] rd_alt_s;
  logic              rd_mem_s;

  d_ff #(.W(DATA_W)) u_addr (.clk(clk), .rst(rst), .en(cpu.addr_in), .d(cpu.bus), .q(addr_q));
  d_ff #(.W(DATA_W)) u_dout (.clk(clk), .rst(rst), .en(cpu.dout_in), .d(cpu.bus), .q(dout_q));
  d_ff #(.W(DATA_W)) u_led  (.clk(clk), .rst(rst), .en(led_we_s),    .d(dout_q),  .q(led));

  assign region_s = decode_region(addr_q[RAM_AW+1:RAM_AW]);
  assign rd_mem_s = (region_s == RGN_RAM);

  // two-flop synchronizer for the switch inputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sw_meta_r <= {DATA_W{1'b0}};
      sw_sync_r <= {DATA_W{1'b0}};
    end else begin
      sw_meta_r <= sw;
      sw_sync_r <= sw_meta_r;
    end
  end

  // write-port arbitration: the loader owns the RAM outside IDLE and w_d is dropped
  always_comb begin
    ram_we_s    = 1'b0;
    ram_waddr_s = addr_q[RAM_AW-1:0];
    ram_wdata_s = dout_q;
    led_we_s    = 1'b0;
    if (ld_state_r == LD_LOAD) begin
      ram_we_s    = ld_valid;
      ram_waddr_s = ld_ptr_r;
      ram_wdata_s = ld_data;
    end else if (ld_state_r == LD_IDLE) begin
      ram_we_s = cpu.w_d && (region_s == RGN_RAM);
      led_we_s = cpu.w_d && (region_s == RGN_LED);
    end else begin
      ram_we_s = 1'b0;
      led_we_s = 1'b0;
    end
  end

  // non-RAM read data
  always_comb begin
    rd_alt_s = {DATA_W{1'b0}};
    case (region_s)
      RGN_LED: rd_alt_s = led;
      RGN_SW:  rd_alt_s = sw_sync_r;
      default: rd_alt_s = {DATA_W{1'b0}};
    endcase
  end

  sync_ram #(.DATA_W(DATA_W), .RAM_AW(RAM_AW)) u_ram (
    .clk(clk), .rst(rst), .we(ram_we_s), .waddr(ram_waddr_s), .wdata(ram_wdata_s),
    .raddr(addr_q[RAM_AW-1:0]), .rd_mem(rd_mem_s), .alt(rd_alt_s), .q(cpu.din)
  );

  // program-loader FSM with registered handshake outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ld_state_r <= LD_IDLE;
      ld_ptr_r   <= {RAM_AW{1'b0}};
      ld_ready   <= 1'b0;
      cpu_hold   <= 1'b0;
      ld_ovf     <= 1'b0;
    end else begin
      case (ld_state_r)
        LD_IDLE: begin
          if (ld_start) begin
            ld_state_r <= LD_LOAD;
            ld_ptr_r   <= {RAM_AW{1'b0}};
            ld_ovf     <= 1'b0;
            ld_ready   <= 1'b1;
            cpu_hold   <= 1'b1;
          end
        end
        LD_LOAD: begin
          if (ld_valid) begin
            ld_ptr_r <= ld_ptr_r + 1'b1;
            if (ld_ptr_r == {RAM_AW{1'b1}}) ld_ovf <= 1'b1;
            if (ld_last) begin
              ld_state_r <= LD_RELEASE;
              ld_ready   <= 1'b0;
            end
          end
        end
        LD_RELEASE: begin
          ld_state_r <= LD_IDLE;
          cpu_hold   <= 1'b0;
        end
        default: begin
          ld_state_r <= LD_IDLE;
          ld_ready   <= 1'b0;
          cpu_hold   <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder with a behavioural memory/loader model checked every cycle.
module tb_mem_responder;
  logic       clk = 1'b0;
  logic       rst;
  logic [8:0] sw;
  logic [8:0] led;
  logic       ld_start, ld_valid, ld_last;
  logic [8:0] ld_data;
  logic       ld_ready, cpu_hold, ld_ovf;

  mem_responder_if #(.DATA_W(9)) cpu ();

  mem_responder #(.DATA_W(9), .RAM_AW(7)) dut (
    .clk(clk), .rst(rst), .cpu(cpu), .sw(sw), .led(led),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
    .ld_ready(ld_ready), .cpu_hold(cpu_hold), .ld_ovf(ld_ovf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // model state: mode 0 = processor owns memory, 1 = loading, 2 = one-cycle release
  logic [8:0] m_mem [128];
  bit         m_known [128];
  logic [8:0] m_addr, m_dout, m_led, m_din, m_sw1, m_sw2;
  bit         m_din_known, m_ovf;
  int         m_mode, m_ptr;

  task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    if (m_din_known) chk("din", cpu.din, m_din);
    chk("led", led, m_led);
    chk("cpu_hold", 9'(cpu_hold), 9'(m_mode != 0));
    chk("ld_ready", 9'(ld_ready), 9'(m_mode == 1));
    chk("ld_ovf", 9'(ld_ovf), 9'(m_ovf));
  endtask

  task automatic model_reset();
    m_addr = 9'h000; m_dout = 9'h000; m_led = 9'h000;
    m_din = 9'h000; m_din_known = 1'b1;
    m_sw1 = 9'h000; m_sw2 = 9'h000;
    m_mode = 0; m_ptr = 0; m_ovf = 1'b0;
  endtask

  // advance the model by one edge from the current inputs, clock the DUT, then compare
  task automatic cycle();
    logic [8:0] n_din;
    bit         n_known;
    n_known = 1'b1;
    case (m_addr[8:7])
      2'b00: begin n_din = m_mem[m_addr[6:0]]; n_known = m_known[m_addr[6:0]]; end
      2'b01: n_din = m_led;
      2'b10: n_din = m_sw2;
      default: n_din = 9'h000;
    endcase
    if (m_mode == 0 && cpu.w_d) begin
      if (m_addr[8:7] == 2'b00) begin
        m_mem[m_addr[6:0]] = m_dout;
        m_known[m_addr[6:0]] = 1'b1;
      end else if (m_addr[8:7] == 2'b01) begin
        m_led = m_dout;
      end
    end
    if (m_mode == 1) begin
      if (ld_valid) begin
        m_mem[m_ptr] = ld_data;
        m_known[m_ptr] = 1'b1;
        if (m_ptr == 127) m_ovf = 1'b1;
        m_ptr = (m_ptr + 1) % 128;
        if (ld_last) m_mode = 2;
      end
    end else if (m_mode == 2) begin
      m_mode = 0;
    end else if (ld_start) begin
      m_mode = 1; m_ptr = 0; m_ovf = 1'b0;
    end
    m_sw2 = m_sw1;
    m_sw1 = sw;
    if (cpu.addr_in) m_addr = cpu.bus;
    if (cpu.dout_in) m_dout = cpu.bus;
    m_din = n_din;
    m_din_known = n_known;
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic strobe(input bit a, input bit d, input logic [8:0] v);
    cpu.bus = v; cpu.addr_in = a; cpu.dout_in = d;
    cycle();
    cpu.addr_in = 1'b0; cpu.dout_in = 1'b0;
  endtask

  task automatic write_cycle();
    cpu.w_d = 1'b1;
    cycle();
    cpu.w_d = 1'b0;
  endtask

  logic [8:0] w3 [3];

  initial begin
    w3[0] = 9'h040; w3[1] = 9'h005; w3[2] = 9'h1C0;
    for (int i = 0; i < 128; i++) begin m_known[i] = 1'b0; m_mem[i] = 9'h000; end
    rst = 1'b0; sw = 9'h000;
    cpu.bus = 9'h000; cpu.addr_in = 1'b0; cpu.dout_in = 1'b0; cpu.w_d = 1'b0;
    ld_start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0; ld_data = 9'h000;
    model_reset();
    #12;
    compare_all();
    chk("rst_din", cpu.din, 9'h000);
    chk("rst_hold", 9'(cpu_hold), 9'h000);
    rst = 1'b1;

    // three-word program load
    ld_start = 1'b1; cycle(); ld_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ld_valid = 1'b1; ld_data = w3[i]; ld_last = (i == 2);
      cycle();
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    chk("hold_release_cycle", 9'(cpu_hold), 9'h001);
    cycle();
    chk("hold_dropped", 9'(cpu_hold), 9'h000);
    chk("ovf_short_load", 9'(ld_ovf), 9'h000);

    // fetch from address 2
    strobe(1'b1, 1'b0, 9'h002);
    cycle();
    chk("fetch_e1", cpu.din, 9'h1C0);
    cycle();
    chk("fetch_steady", cpu.din, 9'h1C0);

    // stores to LED and RAM[16]
    strobe(1'b0, 1'b1, 9'h0AA);
    strobe(1'b1, 1'b0, 9'h080);
    write_cycle();
    chk("led_store", led, 9'h0AA);
    strobe(1'b1, 1'b0, 9'h010);
    strobe(1'b0, 1'b1, 9'h033);
    write_cycle();
    strobe(1'b0, 1'b1, 9'h0AA);
    write_cycle();
    chk("ram_rbw_old", cpu.din, 9'h033);
    cycle();
    chk("ram_rbw_new", cpu.din, 9'h0AA);

    // switch read and ignored write to the switch region
    sw = 9'h155;
    strobe(1'b1, 1'b0, 9'h100);
    cycle();
    cycle();
    chk("sw_read", cpu.din, 9'h155);
    strobe(1'b0, 1'b1, 9'h07F);
    write_cycle();
    chk("sw_write_led", led, 9'h0AA);
    strobe(1'b1, 1'b0, 9'h000);
    cycle();
    chk("sw_write_ram0", cpu.din, 9'h040);
    strobe(1'b1, 1'b0, 9'h180);
    write_cycle();
    cycle();
    chk("none_read", cpu.din, 9'h000);
    strobe(1'b1, 1'b1, 9'h0F0);
    write_cycle();
    chk("dual_strobe_led", led, 9'h0F0);

    // 129-word load wraps onto RAM[0]
    ld_start = 1'b1; cycle(); ld_start = 1'b0;
    for (int i = 0; i < 129; i++) begin
      ld_valid = 1'b1; ld_data = 9'(i * 3 + 1); ld_last = (i == 128);
      cycle();
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    chk("ovf_set", 9'(ld_ovf), 9'h001);
    cycle();
    strobe(1'b1, 1'b0, 9'h000);
    cycle();
    chk("wrap_word", cpu.din, 9'h181);
    chk("ovf_sticky", 9'(ld_ovf), 9'h001);

    // reset in the middle of a load, with w_d attempted during LOAD
    ld_start = 1'b1; cycle(); ld_start = 1'b0;
    chk("ovf_cleared", 9'(ld_ovf), 9'h000);
    ld_valid = 1'b1; ld_data = 9'h011; cpu.bus = 9'h005; cpu.addr_in = 1'b1;
    cycle();
    cpu.addr_in = 1'b0;
    ld_data = 9'h022; cpu.bus = 9'h1FF; cpu.dout_in = 1'b1;
    cycle();
    cpu.dout_in = 1'b0; ld_valid = 1'b0;
    write_cycle();
    rst = 1'b0;
    #2;
    model_reset();
    compare_all();
    chk("abort_hold", 9'(cpu_hold), 9'h000);
    chk("abort_ready", 9'(ld_ready), 9'h000);
    @(posedge clk);
    #1;
    rst = 1'b1;
    cycle();
    chk("abort_ram0", cpu.din, 9'h011);
    strobe(1'b1, 1'b0, 9'h001);
    cycle();
    chk("abort_ram1", cpu.din, 9'h022);
    strobe(1'b1, 1'b0, 9'h005);
    cycle();
    chk("wd_in_load_ignored", cpu.din, 9'h010);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
